// File: rtl/rs_latch_pkg.sv
// Shared encodings for the active-low RS latch driver: command ops, FSM states
// and the pass/fail rule applied when a command completes.
package rs_latch_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_ILL   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  // Width of a down-counter that must hold the larger of two cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  // 1 when the sampled latch outputs do not match what the op should produce.
  function automatic logic check_fail(input op_t op, input logic q, input logic qn);
    case (op)
      OP_SET:   return !(q && !qn);
      OP_RESET: return !(!q && qn);
      OP_HOLD:  return (q == qn);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rs_pulse_timer.sv
// Loadable down-counter shared by the PULSE and SETTLE phases. Stops at zero.
module rs_pulse_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/rs_latch_driver.sv
// Command-side driver for an active-low RS (NAND) latch: accepts SET/RESET/HOLD
// over valid/ready, drives timed active-low pulses on s or r, lets the latch
// settle, then reports done with a pass/fail flag and the sampled q.
module rs_latch_driver
  import rs_latch_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       r,
  output logic       s,
  input  logic       q,
  input  logic       qn,
  output logic       done,
  output logic       err,
  output logic       q_last
);

  localparam int unsigned CW = cnt_width(PULSE_CYC, SETTLE_CYC);

  state_t        state_q;
  op_t           op_q;
  op_t           op_in;
  logic          ready_q;
  logic          r_q;
  logic          s_q;
  logic          done_q;
  logic          err_q;
  logic          qlast_q;
  logic          accept;
  logic          pulse_op;
  logic          tmr_load;
  logic          tmr_expire;
  logic [CW-1:0] tmr_value;

  assign op_in    = op_t'(cmd_op);
  assign accept   = cmd_valid && ready_q;
  assign pulse_op = (op_in == OP_SET) || (op_in == OP_RESET);

  // Timer load on entry to PULSE (from accept) and on entry to SETTLE.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (state_q == ST_IDLE && accept && pulse_op) begin
      tmr_load  = 1'b1;
      tmr_value = CW'(PULSE_CYC);
    end else if (state_q == ST_PULSE && tmr_expire) begin
      tmr_load  = 1'b1;
      tmr_value = CW'(SETTLE_CYC);
    end
  end

  rs_pulse_timer #(
    .W (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // Control FSM with registered r/s/ready/done/err/q_last. The check result is
  // registered on the edge entering CHECK so done/err are visible during CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      ready_q <= 1'b1;
      r_q     <= 1'b1;
      s_q     <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      qlast_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            ready_q <= 1'b0;
            if (pulse_op) begin
              state_q <= ST_PULSE;
              s_q     <= (op_in != OP_SET);
              r_q     <= (op_in != OP_RESET);
            end else begin
              state_q <= ST_CHECK;
              done_q  <= 1'b1;
              err_q   <= check_fail(op_in, q, qn);
              qlast_q <= q;
            end
          end
        end
        ST_PULSE: begin
          if (tmr_expire) begin
            state_q <= ST_SETTLE;
            r_q     <= 1'b1;
            s_q     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_expire) begin
            state_q <= ST_CHECK;
            done_q  <= 1'b1;
            err_q   <= check_fail(op_q, q, qn);
            qlast_q <= q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign r         = r_q;
  assign s         = s_q;
  assign done      = done_q;
  assign err       = err_q;
  assign q_last    = qlast_q;

endmodule
